// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges execute (A) and load (B) writeback requests
// onto the register file's single write port in acceptance order. It also
// publishes a per-register scoreboard of writes still in flight, so decode
// can stall reads of those registers.

// One requester queue: a circular buffer with a valid bit per slot. The valid
// bits are kept so the scoreboard can see exactly which entries are live.
module regfile_write_queue #(
    parameter int WORD  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enq,
    input  logic [4:0]      enq_reg,
    input  logic [WORD-1:0] enq_data,
    input  logic [3:0]      enq_stamp,
    input  logic            deq,
    output logic            full,
    output logic            head_valid,
    output logic [4:0]      head_reg,
    output logic [WORD-1:0] head_data,
    output logic [3:0]      head_stamp,
    output logic [31:0]     busy_mask
);

    // DEPTH is at most 3, so two-bit pointers cover every legal size.
    logic [DEPTH-1:0] slot_valid;
    logic [4:0]       slot_reg   [DEPTH];
    logic [WORD-1:0]  slot_data  [DEPTH];
    logic [3:0]       slot_stamp [DEPTH];
    logic [1:0]       head_ptr;
    logic [1:0]       tail_ptr;

    // Pointers wrap at DEPTH rather than at a power of two.
    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // The queue is full when every slot holds a live entry.
    assign full = &slot_valid;

    // Pointer and occupancy state; enqueue and dequeue may share an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr   <= 2'd0;
            tail_ptr   <= 2'd0;
            slot_valid <= '0;
        end else begin
            if (deq) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (head_ptr == 2'(i)) begin
                        slot_valid[i] <= 1'b0;
                    end
                end
                head_ptr <= ptr_next(head_ptr);
            end
            if (enq) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (tail_ptr == 2'(i)) begin
                        slot_valid[i] <= 1'b1;
                    end
                end
                tail_ptr <= ptr_next(tail_ptr);
            end
        end
    end

    // Payload storage needs no reset because the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tail_ptr == 2'(i)) begin
                    slot_reg[i]   <= enq_reg;
                    slot_data[i]  <= enq_data;
                    slot_stamp[i] <= enq_stamp;
                end
            end
        end
    end

    // Present the oldest entry of this queue to the arbiter.
    always_comb begin
        head_valid = 1'b0;
        head_reg   = '0;
        head_data  = '0;
        head_stamp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (head_ptr == 2'(i)) begin
                head_valid = slot_valid[i];
                head_reg   = slot_reg[i];
                head_data  = slot_data[i];
                head_stamp = slot_stamp[i];
            end
        end
    end

    // Mark every register that has a live entry anywhere in this queue.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                busy_mask[slot_reg[i]] = 1'b1;
            end
        end
    end

endmodule

// Top level: two requester queues, a shared age stamp, an oldest-first
// arbiter, a registered write stage and the pending-write scoreboard.
module regfile_write_arbiter #(
    parameter int WORD  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_reg,
    input  logic [WORD-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_reg,
    input  logic [WORD-1:0] b_data,
    output logic [4:0]      write_register,
    output logic [WORD-1:0] write_data,
    output logic            reg_write,
    input  logic [4:0]      query_reg1,
    input  logic [4:0]      query_reg2,
    output logic            query_pending1,
    output logic            query_pending2,
    output logic [31:0]     pending
);

    localparam logic [4:0] XZR = 5'd31;

    logic            a_enq;
    logic            b_enq;
    logic            a_full;
    logic            b_full;
    logic            a_head_valid;
    logic            b_head_valid;
    logic [4:0]      a_head_reg;
    logic [4:0]      b_head_reg;
    logic [WORD-1:0] a_head_data;
    logic [WORD-1:0] b_head_data;
    logic [3:0]      a_head_stamp;
    logic [3:0]      b_head_stamp;
    logic [31:0]     a_busy;
    logic [31:0]     b_busy;
    logic [3:0]      stamp;
    logic [3:0]      stamp_diff;
    logic            grant_a;
    logic            grant_b;

    // Ready only reflects current occupancy and never looks ahead at a dequeue.
    assign a_ready = !reset && !a_full;
    assign b_ready = !reset && !b_full;

    // Writes to the zero register complete the handshake but are dropped here.
    assign a_enq = a_valid && a_ready && (a_reg != XZR);
    assign b_enq = b_valid && b_ready && (b_reg != XZR);

    regfile_write_queue #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_queue_a (
        .clk        (clk),
        .reset      (reset),
        .enq        (a_enq),
        .enq_reg    (a_reg),
        .enq_data   (a_data),
        .enq_stamp  (stamp),
        .deq        (grant_a),
        .full       (a_full),
        .head_valid (a_head_valid),
        .head_reg   (a_head_reg),
        .head_data  (a_head_data),
        .head_stamp (a_head_stamp),
        .busy_mask  (a_busy)
    );

    regfile_write_queue #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_queue_b (
        .clk        (clk),
        .reset      (reset),
        .enq        (b_enq),
        .enq_reg    (b_reg),
        .enq_data   (b_data),
        .enq_stamp  (stamp),
        .deq        (grant_b),
        .full       (b_full),
        .head_valid (b_head_valid),
        .head_reg   (b_head_reg),
        .head_data  (b_head_data),
        .head_stamp (b_head_stamp),
        .busy_mask  (b_busy)
    );

    // Shared age stamp; same-edge enqueues share one value, so it bumps once.
    always_ff @(posedge clk) begin
        if (reset) begin
            stamp <= 4'd0;
        end else if (a_enq || b_enq) begin
            stamp <= stamp + 4'd1;
        end
    end

    // Oldest head wins. At most seven writes are outstanding, so a signed
    // 4-bit stamp difference is unambiguous across wrap. Ties go to the load.
    always_comb begin
        stamp_diff = a_head_stamp - b_head_stamp;
        grant_a    = a_head_valid && (!b_head_valid || stamp_diff[3]);
        grant_b    = b_head_valid && !grant_a;
    end

    // Registered write stage; address and data hold while no write issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else if (grant_a) begin
            reg_write      <= 1'b1;
            write_register <= a_head_reg;
            write_data     <= a_head_data;
        end else if (grant_b) begin
            reg_write      <= 1'b1;
            write_register <= b_head_reg;
            write_data     <= b_head_data;
        end else begin
            reg_write      <= 1'b0;
        end
    end

    // Scoreboard: queued entries plus the write currently on the port.
    always_comb begin
        pending = a_busy | b_busy;
        if (reg_write) begin
            pending[write_register] = 1'b1;
        end
        pending[31] = 1'b0;
    end

    assign query_pending1 = pending[query_reg1];
    assign query_pending2 = pending[query_reg2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors for regfile_write_arbiter,
// plus hand-written backpressure, zero-register and mid-flight reset sequences.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic [63:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [63:0] b_data;
    logic [4:0]  write_register;
    logic [63:0] write_data;
    logic        reg_write;
    logic [4:0]  query_reg1;
    logic [4:0]  query_reg2;
    logic        query_pending1;
    logic        query_pending2;
    logic [31:0] pending;

    int compared;
    int mismatched;

    regfile_write_arbiter #(
        .WORD  (64),
        .DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_reg          (a_reg),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_reg          (b_reg),
        .b_data         (b_data),
        .write_register (write_register),
        .write_data     (write_data),
        .reg_write      (reg_write),
        .query_reg1     (query_reg1),
        .query_reg2     (query_reg2),
        .query_pending1 (query_pending1),
        .query_pending2 (query_pending2),
        .pending        (pending)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [63:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [63:0] bd;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        ea;
        logic        eb;
        logic        ewe;
        logic [4:0]  ewr;
        logic [63:0] ewd;
        logic [31:0] ep;
        logic        eq1;
        logic        eq2;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [4:0] ar, input logic [63:0] ad,
        input logic bv, input logic [4:0] br, input logic [63:0] bd,
        input logic [4:0] q1, input logic [4:0] q2,
        input logic ea, input logic eb, input logic ewe, input logic [4:0] ewr,
        input logic [63:0] ewd, input logic [31:0] ep, input logic eq1, input logic eq2);
        vec_t v;
        v.rst = rst; v.av = av; v.ar = ar; v.ad = ad;
        v.bv = bv; v.br = br; v.bd = bd; v.q1 = q1; v.q2 = q2;
        v.ea = ea; v.eb = eb; v.ewe = ewe; v.ewr = ewr; v.ewd = ewd;
        v.ep = ep; v.eq1 = eq1; v.eq2 = eq2;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        a_valid    = v.av;
        a_reg      = v.ar;
        a_data     = v.ad;
        b_valid    = v.bv;
        b_reg      = v.br;
        b_data     = v.bd;
        query_reg1 = v.q1;
        query_reg2 = v.q2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Backpressure stimulus and the acceptance-order reference queue.
    logic [4:0]  a_list [6];
    logic [4:0]  b_list [6];
    logic [68:0] exp_q [$];
    logic [68:0] exp_item;

    initial begin
        compared   = 0;
        mismatched = 0;

        // Rows describe one cycle: inputs held during it, outputs seen mid-cycle.
        vecs[0]  = mk(1, 1, 1, 11, 1, 2, 22,   1, 2,  0, 0, 0, 0, 0,     32'h0,   0, 0);
        vecs[1]  = mk(0, 0, 0, 0,  0, 0, 0,    5, 0,  1, 1, 0, 0, 0,     32'h0,   0, 0);
        vecs[2]  = mk(0, 1, 5, 55, 0, 0, 0,    5, 0,  1, 1, 0, 0, 0,     32'h0,   0, 0);
        vecs[3]  = mk(0, 0, 0, 0,  0, 0, 0,    5, 0,  1, 1, 0, 0, 0,     32'h20,  1, 0);
        vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0,    5, 0,  1, 1, 1, 5, 55,    32'h20,  1, 0);
        vecs[5]  = mk(0, 0, 0, 0,  0, 0, 0,    5, 0,  1, 1, 0, 5, 55,    32'h0,   0, 0);
        vecs[6]  = mk(0, 1, 3, 10, 1, 3, -64'sd354, 3, 5, 1, 1, 0, 5, 55, 32'h0,  0, 0);
        vecs[7]  = mk(0, 0, 0, 0,  0, 0, 0,    3, 5,  1, 1, 0, 5, 55,    32'h8,   1, 0);
        vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0,    3, 5,  1, 1, 1, 3, -64'sd354, 32'h8, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0,    3, 5,  1, 1, 1, 3, 10,    32'h8,   1, 0);
        vecs[10] = mk(0, 1, 8, 80, 1, 9, 90,   7, 8,  1, 1, 0, 3, 10,    32'h0,   0, 0);
        vecs[11] = mk(0, 1, 7, 70, 0, 0, 0,    7, 8,  1, 1, 0, 3, 10,    32'h300, 0, 1);
        vecs[12] = mk(0, 0, 0, 0,  1, 7, 77,   7, 9,  0, 1, 1, 9, 90,    32'h380, 1, 1);
        vecs[13] = mk(0, 0, 0, 0,  0, 0, 0,    7, 9,  1, 1, 1, 8, 80,    32'h180, 1, 0);
        vecs[14] = mk(0, 0, 0, 0,  0, 0, 0,    7, 9,  1, 1, 1, 7, 70,    32'h80,  1, 0);
        vecs[15] = mk(0, 0, 0, 0,  0, 0, 0,    7, 9,  1, 1, 1, 7, 77,    32'h80,  1, 0);
        vecs[16] = mk(0, 0, 0, 0,  0, 0, 0,    7, 9,  1, 1, 0, 7, 77,    32'h0,   0, 0);

        // First reset edge with both requesters pushing; state before it is unknown.
        applyStimulus(vecs[0]);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d.a_ready", i), 64'(a_ready), 64'(vecs[i].ea));
            checkOutput($sformatf("row%0d.b_ready", i), 64'(b_ready), 64'(vecs[i].eb));
            checkOutput($sformatf("row%0d.reg_write", i), 64'(reg_write), 64'(vecs[i].ewe));
            checkOutput($sformatf("row%0d.write_register", i), 64'(write_register), 64'(vecs[i].ewr));
            checkOutput($sformatf("row%0d.write_data", i), write_data, vecs[i].ewd);
            checkOutput($sformatf("row%0d.pending", i), 64'(pending), 64'(vecs[i].ep));
            checkOutput($sformatf("row%0d.query_pending1", i), 64'(query_pending1), 64'(vecs[i].eq1));
            checkOutput($sformatf("row%0d.query_pending2", i), 64'(query_pending2), 64'(vecs[i].eq2));
            @(posedge clk);
            #1;
        end

        // Backpressure: both requesters stream until all twelve writes are accepted.
        begin
            int  ai;
            int  bi;
            int  issued;
            int  first_cyc;
            int  last_cyc;
            bit  saw_drop;
            bit  a_acc;
            bit  b_acc;
            a_list = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11};
            b_list = '{5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12};
            ai = 0; bi = 0; issued = 0; first_cyc = -1; last_cyc = -1; saw_drop = 0;
            query_reg1 = 5'd1;
            query_reg2 = 5'd2;
            for (int cyc = 0; cyc < 60 && issued < 12; cyc++) begin
                a_valid = (ai < 6);
                b_valid = (bi < 6);
                a_reg   = (ai < 6) ? a_list[ai] : 5'd0;
                b_reg   = (bi < 6) ? b_list[bi] : 5'd0;
                a_data  = 64'(a_reg) * 64'd1000 + 64'd1;
                b_data  = 64'(b_reg) * 64'd1000 + 64'd2;
                @(negedge clk);
                if (reg_write) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checkOutput("bp.unexpected_write", 64'(write_register), 64'd0);
                    end else begin
                        exp_item = exp_q.pop_front();
                        checkOutput($sformatf("bp.write%0d.reg", issued), 64'(write_register), 64'(exp_item[68:64]));
                        checkOutput($sformatf("bp.write%0d.data", issued), write_data, exp_item[63:0]);
                    end
                    issued++;
                end
                if (!a_ready || !b_ready) saw_drop = 1'b1;
                a_acc = a_valid && a_ready;
                b_acc = b_valid && b_ready;
                @(posedge clk);
                #1;
                // On a shared edge the load carries the same stamp and issues first.
                if (b_acc) begin
                    exp_q.push_back({b_reg, b_data});
                    bi++;
                end
                if (a_acc) begin
                    exp_q.push_back({a_reg, a_data});
                    ai++;
                end
            end
            a_valid = 1'b0;
            b_valid = 1'b0;
            checkOutput("bp.issued_count", 64'(issued), 64'd12);
            checkOutput("bp.ready_dropped", 64'(saw_drop), 64'd1);
            checkOutput("bp.one_per_cycle", 64'(last_cyc - first_cyc + 1), 64'd12);
            checkOutput("bp.leftover_expected", 64'(exp_q.size()), 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("bp.drained_reg_write", 64'(reg_write), 64'd0);
            checkOutput("bp.drained_pending", 64'(pending), 64'd0);
            @(posedge clk);
            #1;
        end

        // Zero-register write: handshake completes but nothing is tracked or written.
        a_valid    = 1'b1;
        a_reg      = 5'd31;
        a_data     = 64'hDEAD;
        query_reg1 = 5'd31;
        @(negedge clk);
        checkOutput("xzr.a_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(negedge clk);
        checkOutput("xzr.pending", 64'(pending), 64'd0);
        checkOutput("xzr.query_pending1", 64'(query_pending1), 64'd0);
        checkOutput("xzr.reg_write_k1", 64'(reg_write), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("xzr.reg_write_k2", 64'(reg_write), 64'd0);
        @(posedge clk);
        #1;

        // Two writes queued on one edge, then reset before either can retire.
        a_valid = 1'b1; a_reg = 5'd20; a_data = 64'd2000;
        b_valid = 1'b1; b_reg = 5'd21; b_data = 64'd2100;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        checkOutput("rst.pending_before", 64'(pending), 64'h0030_0000);
        checkOutput("rst.a_ready_during", 64'(a_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst.reg_write_after", 64'(reg_write), 64'd0);
        checkOutput("rst.pending_after", 64'(pending), 64'd0);
        checkOutput("rst.write_register_after", 64'(write_register), 64'd0);
        checkOutput("rst.write_data_after", write_data, 64'd0);
        checkOutput("rst.a_ready_after", 64'(a_ready), 64'd1);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput($sformatf("rst.no_write_c%0d", j), 64'(reg_write), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: requester A (execute/ALU result) and requester B (memory load result). Each requester has a DEPTH-entry queue. Queued writes are merged onto the write port strictly oldest-first. The block also keeps a pending-write scoreboard that decode queries to stall reads of registers with writes still in flight. It sits between the execute/memory stages and the regfile write inputs (write_register, write_data, reg_write).

## Interface
- WORD, default 64: data width, equal to the codebase `WORD.
- DEPTH, default 2: entries per requester queue. Legal values are 1–3, which keeps outstanding writes ≤ 7.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high reset.
- a_valid  input  1: requester A presents a write.
- a_ready  output  1: A queue can accept.
- a_reg  input  5: A destination register.
- a_data  input  WORD: A write data.
- b_valid, b_ready, b_reg, b_data: same as the A ports, for requester B.
- write_register  output  5: regfile write address.
- write_data  output  WORD: regfile write data.
- reg_write  output  1: regfile write enable.
- query_reg1, query_reg2  input  5: decode source registers.
- query_pending1, query_pending2  output  1: combinational; set when the queried register has a write in flight.
- pending  output  32: per-register in-flight mask.

## Operation
- **Handshake.**
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - x_ready = !reset && queue x not full. It does not depend on x_valid.
  - The requester must hold reg and data stable while valid is high and ready is low.
- **XZR.**
  - A transfer with reg == 31 completes the handshake but is discarded.
  - It is never enqueued, never sets pending, and never drives reg_write.
- **Age stamp.**
  - A 4-bit stamp counter is shared by both queues.
  - Each enqueued entry stores the current stamp.
  - The counter increments by 1 (mod 16) on any edge with at least one enqueue.
  - When A and B enqueue on the same edge, both get the same stamp.
- **Arbitration.** Each cycle, look at the two queue heads:
  - Only one head valid: grant it.
  - Both valid: grant the older head. A is older if (stampA − stampB) mod 16, read as signed 4-bit, is negative.
  - Equal stamps: grant B (the load belongs to the older instruction).
  - Result: writes issue in acceptance order, so two writes to the same register never reorder.
- **Output stage.**
  - The granted head is dequeued and loaded into a registered output stage (write_register, write_data, reg_write = 1).
  - If nothing is granted, reg_write = 0. write_register and write_data then hold their last values.
  - One write issues per cycle at most.
- **Scoreboard.**
  - pending[r] = 1 iff register r matches a valid entry in either queue or the output stage while reg_write = 1.
  - It is derived combinationally from that stored state.
  - query_pendingN = pending[query_regN].
  - pending[31] is always 0.
- **Full queues.** With a queue full, ready is 0. No data is dropped, and the other queue keeps accepting.
- **Simultaneous enqueue and dequeue on the same queue.** Both happen on the same edge; occupancy is unchanged. A full queue still shows ready = 0 that cycle, because ready does not look ahead.

## Timing
- **Reset** (synchronous; takes effect on the first rising edge with reset = 1):
  - Queues are emptied and the stamp counter returns to 0.
  - reg_write = 0, write_register = 0, write_data = 0, pending = 0.
  - a_ready = b_ready = 0 while reset is high, and 1 in the first cycle after reset is released.
- **Reset mid-operation:** all queued and output-stage writes are abandoned. No reg_write pulse occurs after the reset edge.
- **Latency:**
  - A write accepted at edge k into an empty system drives reg_write = 1 from edge k+1 to edge k+2.
  - The regfile's delayed write clock captures it within that cycle.
- **pending timing:**
  - Rises at the accept edge k.
  - Falls at the edge where the output stage holding r is vacated or replaced by a different register (k+2 at minimum), unless another in-flight write to r remains.
- **Throughput:** with continuous traffic, one write per cycle. Combined input rate above 1 per cycle backs up into the queues, and ready falls.

## Test plan
- **Reset.** Assert reset for 2 cycles with a_valid = b_valid = 1.
  - Required: no transfers; all outputs are 0 and ready is 0.
  - Release reset: ready = 1 on the next cycle.
- **Single write.** A writes reg 5, data 55, at edge k.
  - Required: reg_write = 1, write_register = 5, write_data = 55 during k+1..k+2.
  - pending[5] = 1 from k through k+2, and query_pending1 = 1 when query_reg1 = 5.
- **Same-edge conflict.** A (reg 3, data 10) and B (reg 3, data −354) accepted on the same edge.
  - Required: B issues first, then A on the next cycle.
  - pending[3] stays high until A's write completes.
- **Ordering.** B reg 7 accepted at edge k; A reg 7 accepted at edge k−1 while the output stage is busy.
  - Required: A's write to 7 issues before B's, per the stamp order.
- **Backpressure.** With DEPTH = 2, hold a_valid and b_valid high for 6 cycles with distinct registers 1–12.
  - Required: ready drops, exactly one reg_write per cycle, all 12 writes appear in acceptance order, none lost.
- **XZR and reset mid-flight.** A writes reg 31, then two queued writes are followed by reset.
  - Required: the reg 31 handshake completes, but reg_write and pending[31] stay 0.
  - No write issues after the reset edge, and pending = 0.
